// File: rtl/apb_mem_slv.sv
// APB4 word-addressed memory completer with configurable width, depth, wait states and byte strobes.
// Optional define APB_MEM_SLV_PPROT_EN adds PPROT and blocks non-secure access to the low SECURE_WORDS words.
module apb_mem_slv #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 256,
  parameter int unsigned WAIT_STATES  = 0
`ifdef APB_MEM_SLV_PPROT_EN
  ,
  parameter int unsigned SECURE_WORDS = 16
`endif
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  input  logic [ADDR_WIDTH-1:0]     PADDR,
  input  logic                      PWRITE,
  input  logic [DATA_WIDTH-1:0]     PWDATA,
  input  logic [DATA_WIDTH/8-1:0]   PSTRB,
`ifdef APB_MEM_SLV_PPROT_EN
  input  logic [2:0]                PPROT,
`endif
  output logic                      PREADY,
  output logic [DATA_WIDTH-1:0]     PRDATA,
  output logic                      PSLVERR
);

  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned LSB   = $clog2(NB);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] LSB_MASK = ADDR_WIDTH'((1 << LSB) - 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(DEPTH);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    write_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [NB-1:0]           strb_q;
  logic [3:0]              cnt_q;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [ADDR_WIDTH-1:0]   acc_addr;
  logic                    acc_write;
  logic [ADDR_WIDTH-1:0]   word_idx;
  logic                    err;
  logic [DATA_WIDTH-1:0]   rsp_data;
  logic                    setup, complete, abort, mem_we;
  logic                    pready_d, pslverr_d;
  logic [DATA_WIDTH-1:0]   prdata_d;

`ifdef APB_MEM_SLV_PPROT_EN
  localparam logic [ADDR_WIDTH-1:0] SEC_A = ADDR_WIDTH'(SECURE_WORDS);
  logic prot_ns_q;
  logic acc_ns;
  logic pprot_unused;
  assign pprot_unused = PPROT[0] ^ PPROT[2];
`endif

  // Zero-wait responses are formed on the setup edge itself, so the
  // decode looks at the live bus in IDLE and at the captured copy in ACCESS.
  always_comb begin
    acc_addr  = (state == IDLE) ? PADDR  : addr_q;
    acc_write = (state == IDLE) ? PWRITE : write_q;
    word_idx  = acc_addr >> LSB;
    err       = (|(acc_addr & LSB_MASK)) || (word_idx >= DEPTH_A);
`ifdef APB_MEM_SLV_PPROT_EN
    acc_ns    = (state == IDLE) ? PPROT[1] : prot_ns_q;
    err       = err || (acc_ns && (word_idx < SEC_A));
`endif
    rsp_data  = '0;
    if (!err && !acc_write)
      rsp_data = mem[word_idx[IDX_W-1:0]];
  end

  assign setup    = (state == IDLE)   && PSEL && !PENABLE;
  assign complete = (state == ACCESS) && PSEL && PENABLE && PREADY;
  assign abort    = (state == ACCESS) && !PSEL;
  assign mem_we   = complete && write_q && !err;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (setup)            state_nxt = ACCESS;
      ACCESS:  if (abort || complete) state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pready_d  = PREADY;
    pslverr_d = PSLVERR;
    prdata_d  = PRDATA;
    case (state)
      IDLE: begin
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        if (setup && (WAIT_STATES == 0)) begin
          pready_d  = 1'b1;
          pslverr_d = err;
          prdata_d  = rsp_data;
        end
      end
      ACCESS: begin
        if (abort || complete) begin
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          prdata_d  = '0;
        end else if (cnt_q == 4'd1) begin
          pready_d  = 1'b1;
          pslverr_d = err;
          prdata_d  = rsp_data;
        end
      end
      default: begin
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      cnt_q     <= '0;
      PREADY    <= 1'b0;
      PSLVERR   <= 1'b0;
      PRDATA    <= '0;
`ifdef APB_MEM_SLV_PPROT_EN
      prot_ns_q <= 1'b0;
`endif
    end else begin
      if (setup) begin
        addr_q    <= PADDR;
        write_q   <= PWRITE;
        wdata_q   <= PWDATA;
        strb_q    <= PSTRB;
        cnt_q     <= 4'(WAIT_STATES);
`ifdef APB_MEM_SLV_PPROT_EN
        prot_ns_q <= PPROT[1];
`endif
      end else if ((state == ACCESS) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      PREADY  <= pready_d;
      PSLVERR <= pslverr_d;
      PRDATA  <= prdata_d;
    end
  end

  always_ff @(posedge PCLK) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (strb_q[b])
          mem[word_idx[IDX_W-1:0]][b*8 +: 8] <= wdata_q[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_apb_mem_slv.sv
// Directed bench for apb_mem_slv: a zero-wait instance (u0) and a 3-wait instance (u1) on a shared bus.
module tb_apb_mem_slv;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        PENABLE = 1'b0;
  logic [31:0] PADDR = '0;
  logic        PWRITE = 1'b0;
  logic [31:0] PWDATA = '0;
  logic [3:0]  PSTRB = '0;
  logic [1:0]  psel = '0;
  logic [1:0]  ready;
  logic [1:0]  slverr;
  logic [31:0] rdata0, rdata1;
`ifdef APB_MEM_SLV_PPROT_EN
  logic [2:0]  pprot = 3'b000;
`endif

  int checks = 0;
  int errors = 0;

  always #5 PCLK = ~PCLK;

  apb_mem_slv #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(0)) u0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[0]), .PENABLE(PENABLE), .PADDR(PADDR),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
`ifdef APB_MEM_SLV_PPROT_EN
    .PPROT(pprot),
`endif
    .PREADY(ready[0]), .PRDATA(rdata0), .PSLVERR(slverr[0]));

  apb_mem_slv #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(3)) u1 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[1]), .PENABLE(PENABLE), .PADDR(PADDR),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
`ifdef APB_MEM_SLV_PPROT_EN
    .PPROT(pprot),
`endif
    .PREADY(ready[1]), .PRDATA(rdata1), .PSLVERR(slverr[1]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_of(input int d);
    return (d == 0) ? rdata0 : rdata1;
  endfunction

  // Called #1 after a clock edge; drives setup immediately so transfers run back-to-back.
  task automatic xfer(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] strb, input bit scramble,
                      output logic [31:0] rd, output logic err, output int waits, output int lat);
    bit got;
    psel[d] = 1'b1; PENABLE = 1'b0; PADDR = addr; PWRITE = wr; PWDATA = wd; PSTRB = strb;
    @(posedge PCLK); #1;
    lat = 1;
    PENABLE = 1'b1;
    if (scramble) begin
      PADDR = 32'h10; PWDATA = '0; PWRITE = ~wr;
    end
    waits = 0;
    got = 1'b0;
    while (!got && waits < 40) begin
      if (ready[d]) got = 1'b1;
      else begin
        @(posedge PCLK); #1;
        waits++; lat++;
      end
    end
    chk("ready_seen", got, 1);
    rd  = rd_of(d);
    err = slverr[d];
    @(posedge PCLK); #1;
    lat++;
    psel[d] = 1'b0; PENABLE = 1'b0;
    chk("post_done_clear", {ready[d], slverr[d], rd_of(d)}, 0);
  endtask

  task automatic do_wr(input int d, input logic [31:0] a, input logic [31:0] data,
                       input logic [3:0] s, input logic exp_err, input string tag);
    logic [31:0] rd; logic err; int w, l;
    xfer(d, 1'b1, a, data, s, 1'b0, rd, err, w, l);
    chk({tag, ".err"}, err, exp_err);
  endtask

  task automatic do_rd(input int d, input logic [31:0] a, input logic [31:0] exp,
                       input logic exp_err, input string tag);
    logic [31:0] rd; logic err; int w, l;
    xfer(d, 1'b0, a, 32'hFFFF_FFFF, 4'h0, 1'b0, rd, err, w, l);
    chk({tag, ".data"}, rd, exp);
    chk({tag, ".err"}, err, exp_err);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd; logic err; int w, l;

    #3;
    chk("reset_outputs", {ready, slverr, rdata0, rdata1}, 0);
    @(negedge PCLK); PRESETn = 1'b1;
    @(posedge PCLK); #1;

    // zero-wait write/read
    do_wr(0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, "w10");
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, rd, err, w, l);
    chk("r10.data", rd, 32'hDEADBEEF);
    chk("r10.err", err, 0);
    chk("r10.waits", w, 0);
    chk("r10.latency", l, 2);

    // byte strobes, then zero-strobe write
    do_wr(0, 32'h20, 32'h11223344, 4'hF, 1'b0, "w20a");
    do_wr(0, 32'h20, 32'hAABBCCDD, 4'h5, 1'b0, "w20b");
    do_rd(0, 32'h20, 32'h11BB33DD, 1'b0, "r20");
    do_wr(0, 32'h20, 32'hFFFFFFFF, 4'h0, 1'b0, "w20z");
    do_rd(0, 32'h20, 32'h11BB33DD, 1'b0, "r20z");

    // error decode
    do_wr(0, 32'h3FC, 32'h5A5A5A5A, 4'hF, 1'b0, "w3fc");
    do_wr(0, 32'h000, 32'h01234567, 4'hF, 1'b0, "w000");
    do_rd(0, 32'h402, 32'h0, 1'b1, "r402");
    do_wr(0, 32'h400, 32'hFFFFFFFF, 4'hF, 1'b1, "w400");
    do_wr(0, 32'h3FE, 32'hFFFFFFFF, 4'hF, 1'b1, "w3fe");
    do_rd(0, 32'h3FC, 32'h5A5A5A5A, 1'b0, "r3fc");
    do_rd(0, 32'h000, 32'h01234567, 1'b0, "r000");

    // PSEL with PENABLE seen in IDLE must be ignored
    psel[0] = 1'b1; PENABLE = 1'b1; PADDR = 32'h10; PWRITE = 1'b0;
    @(posedge PCLK); #1;
    chk("viol.c1", ready[0], 0);
    @(posedge PCLK); #1;
    chk("viol.c2", ready[0], 0);
    psel[0] = 1'b0; PENABLE = 1'b0;
    do_rd(0, 32'h10, 32'hDEADBEEF, 1'b0, "viol.r10");

    // three wait states
    do_wr(1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, "ws.w10");
    xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, rd, err, w, l);
    chk("ws.r10.data", rd, 32'hDEADBEEF);
    chk("ws.r10.waits", w, 3);
    chk("ws.r10.latency", l, 5);

    // bus changes during ACCESS are ignored
    xfer(1, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF, 1'b1, rd, err, w, l);
    chk("scr.err", err, 0);
    do_rd(1, 32'h30, 32'hCAFEF00D, 1'b0, "scr.r30");
    do_rd(1, 32'h10, 32'hDEADBEEF, 1'b0, "scr.r10");

    // abort after one wait cycle
    psel[1] = 1'b1; PENABLE = 1'b0; PADDR = 32'h10; PWRITE = 1'b1; PWDATA = 32'h0; PSTRB = 4'hF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    chk("abort.wait", ready[1], 0);
    psel[1] = 1'b0; PENABLE = 1'b0;
    repeat (4) @(posedge PCLK);
    #1;
    chk("abort.idle", {ready[1], slverr[1], rdata1}, 0);
    do_rd(1, 32'h10, 32'hDEADBEEF, 1'b0, "abort.r10");

    // reset while a read response is being presented
    psel[1] = 1'b1; PENABLE = 1'b0; PADDR = 32'h10; PWRITE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    repeat (3) @(posedge PCLK);
    #1;
    chk("rst.pre_ready", {ready[1], rdata1}, {1'b1, 32'hDEADBEEF});
    #2 PRESETn = 1'b0;
    #1 chk("rst.rd_clear", {ready[1], slverr[1], rdata1}, 0);
    psel[1] = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK); PRESETn = 1'b1;
    @(posedge PCLK); #1;

    // reset while a write is ready to complete: write must not land
    psel[1] = 1'b1; PENABLE = 1'b0; PADDR = 32'h10; PWRITE = 1'b1; PWDATA = 32'h0; PSTRB = 4'hF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    repeat (3) @(posedge PCLK);
    #1;
    chk("rstw.pre_ready", ready[1], 1);
    #2 PRESETn = 1'b0;
    #1 chk("rstw.clear", {ready[1], slverr[1], rdata1}, 0);
    psel[1] = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK); PRESETn = 1'b1;
    @(posedge PCLK); #1;
    xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, rd, err, w, l);
    chk("rst.after.data", rd, 32'hDEADBEEF);
    chk("rst.after.waits", w, 3);
    do_rd(0, 32'h20, 32'h11BB33DD, 1'b0, "rst.mem_kept");

`ifdef APB_MEM_SLV_PPROT_EN
    pprot = 3'b000;
    do_wr(0, 32'h04, 32'h0BADF00D, 4'hF, 1'b0, "prot.init");
    pprot = 3'b010;
    do_wr(0, 32'h04, 32'h12345678, 4'hF, 1'b1, "prot.ns_wr");
    do_rd(0, 32'h04, 32'h0, 1'b1, "prot.ns_rd");
    pprot = 3'b000;
    do_rd(0, 32'h04, 32'h0BADF00D, 1'b0, "prot.kept");
    do_wr(0, 32'h04, 32'h12345678, 4'hF, 1'b0, "prot.s_wr");
    do_rd(0, 32'h04, 32'h12345678, 1'b0, "prot.s_rd");
    pprot = 3'b010;
    do_wr(0, 32'h40, 32'h0F0F0F0F, 4'hF, 1'b0, "prot.ns_hi_wr");
    do_rd(0, 32'h40, 32'h0F0F0F0F, 1'b0, "prot.ns_hi_rd");
    pprot = 3'b000;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
